uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 4..256.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8, meaning character width.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 4, meaning cycles to wait for tx_busy to rise after a launch.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning an asynchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1, meaning a CPU write strobe that pushes one character per cycle.
REQ-007 SHALL have port wr_data, input, PAYLOAD_BITS, meaning the character to push.
REQ-008 SHALL have port ovf_clr, input, 1, meaning clear the sticky overflow flag.
REQ-009 SHALL have port tx_busy, input, 1, meaning the downstream UART transmitter is busy.
REQ-010 SHALL have port tx_en, output, 1, meaning a one-cycle launch strobe to the transmitter.
REQ-011 SHALL have port tx_data, output, PAYLOAD_BITS, meaning the character launched with tx_en.
REQ-012 SHALL have port full, output, 1, meaning count equals DEPTH.
REQ-013 SHALL have port empty, output, 1, meaning count equals 0.
REQ-014 SHALL have port status, output, 32, meaning a CPU status word: [31] full, [30] empty, [29] overflow, [28] tx_busy, [25:24] FSM state, [8:0] count, all other bits 0.

Function
REQ-015 SHALL implement a circular buffer with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0, and a count of log2(DEPTH)+1 bits.
REQ-016 SHALL push wr_data at the clock edge when wr_en=1 and full=0.
REQ-017 SHALL drop a write when wr_en=1 and full=1, even if a pop occurs in the same cycle, and SHALL set overflow=1.
REQ-018 SHALL keep overflow set until ovf_clr=1; if ovf_clr and a dropped write occur in the same cycle, overflow SHALL remain 1.
REQ-019 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL register full and empty, so that both reflect count after each edge.
REQ-021 SHALL implement an FSM with state encoding IDLE=0, SEND=1, WAIT_HI=2, WAIT_LO=3.
REQ-022 SHALL transition from IDLE to SEND when empty=0 and tx_busy=0; in that transition it SHALL register tx_data from the FIFO head, set tx_en=1, and pop one entry.
REQ-023 SHALL, in SEND, hold tx_en=1 for exactly one cycle and then go to WAIT_HI.
REQ-024 SHALL, in WAIT_HI, go to WAIT_LO when tx_busy=1.
REQ-025 SHALL, in WAIT_HI, return to IDLE after BUSY_TIMEOUT cycles without tx_busy=1; the character is considered sent.
REQ-026 SHALL, in WAIT_LO, return to IDLE when tx_busy=0.
REQ-027 SHALL keep tx_en=0 in every state other than SEND.
REQ-028 SHALL hold tx_data stable from its launch until the next launch.
REQ-029 SHALL give a latency of 2 edges from an accepted write into an empty FIFO (with tx_busy=0) to tx_en=1.
REQ-030 SHALL limit launches to at most one per transmitted character, and never launch while tx_busy=1.
REQ-031 SHALL pop exactly one entry per launch; the FIFO SHALL never underflow.

Reset
REQ-032 SHALL, while rst=1, immediately force the following asynchronously: pointers 0, count 0, empty=1, full=0, overflow=0, state IDLE, tx_en=0, tx_data=0.
REQ-033 SHALL discard FIFO contents and any in-flight launch on reset; after reset, operation resumes from the first write accepted after rst deasserts.

Verification
REQ-034 Write 0x41 into an empty FIFO with tx_busy=0 -> tx_en=1 exactly 2 edges later with tx_data=0x41, then the FIFO empties.
REQ-035 Write 17 characters back-to-back with DEPTH=16 and tx_busy held 1 -> count=16, full=1, overflow=1, and the 17th character is absent from the output.
REQ-036 Write 3 characters with tx_busy modelled as high for 10 cycles, starting 1 cycle after each tx_en -> three tx_en pulses, in order, each at least 11 cycles apart, none while tx_busy=1.
REQ-037 Launch a character while tx_busy never rises -> the FSM returns to IDLE after 4 cycles in WAIT_HI, and the next character launches.
REQ-038 Push and pop on the same cycle with count=16 -> the write is dropped, overflow=1, count=15; then assert ovf_clr -> overflow=0.
REQ-039 Assert rst during WAIT_LO with 5 entries queued -> all outputs take their reset values immediately, and no tx_en occurs after rst deasserts until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Character FIFO in front of a UART transmitter: buffers CPU writes and launches one
// character per transmission, pacing launches on the transmitter's busy handshake.
module uart_tx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic                    ovf_clr,
    input  logic                    tx_busy,
    output logic                    tx_en,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    output logic                    full,
    output logic                    empty,
    output logic [31:0]             status
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSend   = 2'd1,
        StWaitHi = 2'd2,
        StWaitLo = 2'd3
    } state_e;

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [AW:0]             count_q;
    logic [AW:0]             count_d;
    logic                    full_q;
    logic                    empty_q;
    logic                    ovf_q;
    state_e                  state_q;
    logic [TW-1:0]           timer_q;
    logic                    tx_en_q;
    logic [PAYLOAD_BITS-1:0] tx_data_q;
    logic                    push;
    logic                    drop;
    logic                    pop;
    logic [8:0]              count_ext;

    // Pushes are gated on the registered full flag, so a pop in the same cycle does
    // not make room for a write that arrives while full.
    assign push = wr_en & ~full_q;
    assign drop = wr_en & full_q;
    assign pop  = (state_q == StIdle) & ~empty_q & ~tx_busy;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
            // A dropped write wins over a simultaneous clear.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q   <= StSend;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= mem[rd_ptr_q];
                    end
                end
                StSend: begin
                    state_q <= StWaitHi;
                    tx_en_q <= 1'b0;
                    timer_q <= '0;
                end
                StWaitHi: begin
                    // A transmitter that never raises busy is assumed to have sent it.
                    if (tx_busy) begin
                        state_q <= StWaitLo;
                    end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StWaitLo: begin
                    if (!tx_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign count_ext = 9'(count_q);

    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign status  = {full_q, empty_q, ovf_q, tx_busy, 2'b00, state_q, 15'd0, count_ext};

endmodule
